seven_seg_scan_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver that replaces the per-digit static decoders with a single shared segment bus and one-hot digit strobes. Snapshots NUM_DIGITS packed BCD/hex nibbles once per frame, decodes them with optional hex glyphs, leading-zero suppression and decimal points, and scans the digits at a programmable rate with an anti-ghosting blank window. Sits between the time/counter datapath and the board display pins.

---
 rtl/seven_seg_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver
// Description : Time-multiplexed seven-segment driver. Snapshots the packed
//               digit nibbles once per frame, decodes them (optional hex
//               glyphs, leading-zero suppression, decimal points) onto one
//               shared segment bus, and scans one-hot digit strobes with a
//               blank window at the start of every slot against ghosting.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 16,
    parameter int HEX_EN      = 0,
    parameter int SEG_ACT_LOW = 0,
    parameter int DIG_ACT_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic [4*NUM_DIGITS-1:0] i_digit_data,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic                    i_lz_en,
    output logic [6:0]              o_seg_out,
    output logic                    o_dp_out,
    output logic [NUM_DIGITS-1:0]   o_dig_sel,
    output logic                    o_frame_tick
);

    localparam int                      c_cnt_w   = $clog2(SCAN_DIV);
    localparam int                      c_idx_w   = $clog2(NUM_DIGITS);
    localparam logic [c_cnt_w-1:0]      c_cnt_max = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0]      c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]      c_blank   = c_cnt_w'(BLANK_CYC);
    localparam logic [c_idx_w-1:0]      c_idx_max = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_idx_w-1:0]      c_idx_one = c_idx_w'(1);
    localparam logic [NUM_DIGITS-1:0]   c_dig_one = NUM_DIGITS'(1);
    localparam logic                    c_seg_inv = (SEG_ACT_LOW != 0);
    localparam logic                    c_dig_inv = (DIG_ACT_LOW != 0);

    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_idx_w-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_snap_data;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic                    r_snap_lz;
    logic                    r_frame_tick;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_dig;

    logic                    w_cnt_wrap;
    logic                    w_idx_wrap;
    logic                    w_snap_load;
    logic                    w_show;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic                    w_upper_blank;
    logic [3:0]              w_nib;
    logic                    w_supp_cur;
    logic                    w_dp_cur;
    logic [NUM_DIGITS-1:0]   w_onehot;

    // Glyph table; codes A-E fall back to the legacy "6" pattern without hex.
    function automatic logic [6:0] f_decode(input logic [3:0] i_nib);
        logic [6:0] v_seg;
        v_seg = 7'b0000000;
        case (i_nib)
            4'h0:    v_seg = 7'b1111110;
            4'h1:    v_seg = 7'b0110000;
            4'h2:    v_seg = 7'b1101101;
            4'h3:    v_seg = 7'b1111001;
            4'h4:    v_seg = 7'b0110011;
            4'h5:    v_seg = 7'b1011011;
            4'h6:    v_seg = 7'b1011111;
            4'h7:    v_seg = 7'b1110010;
            4'h8:    v_seg = 7'b1111111;
            4'h9:    v_seg = 7'b1111011;
            4'hA:    v_seg = (HEX_EN != 0) ? 7'b1110111 : 7'b1011111;
            4'hB:    v_seg = (HEX_EN != 0) ? 7'b0011111 : 7'b1011111;
            4'hC:    v_seg = (HEX_EN != 0) ? 7'b1001110 : 7'b1011111;
            4'hD:    v_seg = (HEX_EN != 0) ? 7'b0111101 : 7'b1011111;
            4'hE:    v_seg = (HEX_EN != 0) ? 7'b1001111 : 7'b1011111;
            default: v_seg = 7'b0000000;
        endcase
        return v_seg;
    endfunction

    assign w_cnt_wrap  = (r_cnt == c_cnt_max);
    assign w_idx_wrap  = (r_idx == c_idx_max);
    assign w_snap_load = i_enable && (r_cnt == '0) && (r_idx == '0);
    assign w_show      = i_enable && (r_cnt >= c_blank);

    // Slot counter and digit index; disabling parks both at the frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (!i_enable) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt <= '0;
            r_idx <= w_idx_wrap ? '0 : (r_idx + c_idx_one);
        end else begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // Frame snapshot so mid-frame input changes never tear the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_data  <= '0;
            r_snap_dp    <= '0;
            r_snap_lz    <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_snap_load;
            if (w_snap_load) begin
                r_snap_data <= i_digit_data;
                r_snap_dp   <= i_dp_in;
                r_snap_lz   <= i_lz_en;
            end
        end
    end

    // Leading-zero mask: walk from the top digit down while everything seen is 0 or F.
    always_comb begin
        w_supp        = '0;
        w_upper_blank = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_supp[i]     = r_snap_lz && w_upper_blank && (r_snap_data[4*i +: 4] == 4'h0);
            w_upper_blank = w_upper_blank &&
                            ((r_snap_data[4*i +: 4] == 4'h0) || (r_snap_data[4*i +: 4] == 4'hF));
        end
    end

    assign w_nib      = r_snap_data[{r_idx, 2'b00} +: 4];
    assign w_supp_cur = w_supp[r_idx];
    assign w_dp_cur   = r_snap_dp[r_idx];
    assign w_onehot   = c_dig_one << r_idx;

    // Registered display outputs, held dark during the blank window and when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= '0;
            r_dp  <= 1'b0;
            r_dig <= '0;
        end else if (!w_show) begin
            r_seg <= '0;
            r_dp  <= 1'b0;
            r_dig <= '0;
        end else begin
            r_seg <= w_supp_cur ? 7'b0000000 : f_decode(w_nib);
            r_dp  <= w_dp_cur;
            r_dig <= w_onehot;
        end
    end

    // Pin polarity applied after the registers so reset lands on the inactive level.
    assign o_seg_out    = r_seg ^ {7{c_seg_inv}};
    assign o_dp_out     = r_dp ^ c_seg_inv;
    assign o_dig_sel    = r_dig ^ {NUM_DIGITS{c_dig_inv}};
    assign o_frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_driver
// Description : Directed bench for seven_seg_scan_driver. Instance A is
//               active-high without hex glyphs, instance B is active-low with
//               hex glyphs; both share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_driver;

    localparam logic [6:0] G0  = 7'b1111110;
    localparam logic [6:0] G1  = 7'b0110000;
    localparam logic [6:0] G2  = 7'b1101101;
    localparam logic [6:0] G3  = 7'b1111001;
    localparam logic [6:0] G4  = 7'b0110011;
    localparam logic [6:0] G7  = 7'b1110010;
    localparam logic [6:0] G8  = 7'b1111111;
    localparam logic [6:0] GL  = 7'b1011111;
    localparam logic [6:0] GHA = 7'b1110111;
    localparam logic [6:0] GHB = 7'b0011111;
    localparam logic [6:0] GHC = 7'b1001110;
    localparam logic [6:0] GHD = 7'b0111101;
    localparam logic [6:0] GHE = 7'b1001111;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  dig_a, dig_b;
    logic        tick_a, tick_b;

    int vectors;
    int miscompares;

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2),
        .HEX_EN(0), .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_digit_data(data),
        .i_dp_in(dp_in), .i_lz_en(lz_en), .o_seg_out(seg_a), .o_dp_out(dp_a),
        .o_dig_sel(dig_a), .o_frame_tick(tick_a)
    );

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2),
        .HEX_EN(1), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_digit_data(data),
        .i_dp_in(dp_in), .i_lz_en(lz_en), .o_seg_out(seg_b), .o_dp_out(dp_b),
        .o_dig_sel(dig_b), .o_frame_tick(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // At most one digit strobe may be active on either instance.
    always @(negedge clk) begin
        vectors++;
        if (!$onehot0(dig_a) || !$onehot0(~dig_b)) begin
            miscompares++;
            $display("FAIL onehot dig_a=%b dig_b=%b (need at most one active)", dig_a, dig_b);
        end
    end

    // Restart scanning from digit 0; the next negedge is sample k=0 (snapshot cycle).
    task automatic start_scan();
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; data = 16'h1234; dp_in = 4'hF; lz_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) rst_n = 1'b1;
            @(negedge clk);
            vectors++;
            if ({tick_a, dp_a, dig_a, seg_a} !== 13'h0) begin
                miscompares++;
                $display("FAIL reset_a i=%0d got %b need %b", i, {tick_a, dp_a, dig_a, seg_a}, 13'h0);
            end
            vectors++;
            if ({tick_b, dp_b, dig_b, seg_b} !== {1'b0, 1'b1, 4'hF, 7'h7F}) begin
                miscompares++;
                $display("FAIL reset_b i=%0d got %b need %b", i, {tick_b, dp_b, dig_b, seg_b},
                         {1'b0, 1'b1, 4'hF, 7'h7F});
            end
        end
    endtask

    task automatic test_scan_timing();
        logic [6:0] tbl [4];
        logic [6:0] es;
        logic [3:0] ed;
        logic       et;
        int         d, c;
        tbl[0] = G4; tbl[1] = G3; tbl[2] = G2; tbl[3] = G1;
        data = 16'h1234; dp_in = 4'h0; lz_en = 1'b0;
        start_scan();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            d  = (k / 8) % 4;
            c  = k % 8;
            et = ((k % 32) == 0);
            ed = (c < 2) ? 4'b0000 : (4'b0001 << d);
            es = (c < 2) ? 7'b0000000 : tbl[d];
            vectors++;
            if ({tick_a, dig_a, seg_a, dp_a} !== {et, ed, es, 1'b0}) begin
                miscompares++;
                $display("FAIL scan_a k=%0d got %b need %b", k, {tick_a, dig_a, seg_a, dp_a}, {et, ed, es, 1'b0});
            end
            vectors++;
            if ({tick_b, dig_b, seg_b, dp_b} !== {et, ~ed, ~es, 1'b1}) begin
                miscompares++;
                $display("FAIL scan_b k=%0d got %b need %b", k, {tick_b, dig_b, seg_b, dp_b}, {et, ~ed, ~es, 1'b1});
            end
        end
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if ({tick_a, dig_a, seg_a, dp_a, dig_b, seg_b, dp_b} !== {13'h0, 4'hF, 7'h7F, 1'b1}) begin
            miscompares++;
            $display("FAIL disable got %b need %b", {tick_a, dig_a, seg_a, dp_a, dig_b, seg_b, dp_b},
                     {13'h0, 4'hF, 7'h7F, 1'b1});
        end
    endtask

    task automatic test_lz();
        logic [15:0] sd [3];
        logic        sl [3];
        logic [3:0]  sp [3];
        logic [6:0]  tbl [3][4];
        logic [3:0]  ed;
        int          d;
        sd[0] = 16'h0070; sl[0] = 1'b1; sp[0] = 4'b0100;
        tbl[0][0] = G0; tbl[0][1] = G7; tbl[0][2] = 7'h00; tbl[0][3] = 7'h00;
        sd[1] = 16'h0070; sl[1] = 1'b0; sp[1] = 4'b0000;
        tbl[1][0] = G0; tbl[1][1] = G7; tbl[1][2] = G0;    tbl[1][3] = G0;
        sd[2] = 16'hF000; sl[2] = 1'b1; sp[2] = 4'b0000;
        tbl[2][0] = G0; tbl[2][1] = 7'h00; tbl[2][2] = 7'h00; tbl[2][3] = 7'h00;
        for (int s = 0; s < 3; s++) begin
            data = sd[s]; lz_en = sl[s]; dp_in = sp[s];
            start_scan();
            for (int k = 0; k < 32; k++) begin
                @(negedge clk);
                if ((k % 8) == 4) begin
                    d  = k / 8;
                    ed = 4'b0001 << d;
                    vectors++;
                    if ({dig_a, seg_a, dp_a} !== {ed, tbl[s][d], sp[s][d]}) begin
                        miscompares++;
                        $display("FAIL lz_a s=%0d d=%0d got %b need %b", s, d, {dig_a, seg_a, dp_a},
                                 {ed, tbl[s][d], sp[s][d]});
                    end
                    vectors++;
                    if ({dig_b, seg_b, dp_b} !== {~ed, ~tbl[s][d], ~sp[s][d]}) begin
                        miscompares++;
                        $display("FAIL lz_b s=%0d d=%0d got %b need %b", s, d, {dig_b, seg_b, dp_b},
                                 {~ed, ~tbl[s][d], ~sp[s][d]});
                    end
                end
            end
        end
    endtask

    task automatic test_hex();
        logic [15:0] sd [2];
        logic [6:0]  ta [2][4];
        logic [6:0]  tb [2][4];
        int          d;
        sd[0] = 16'hABCE;
        ta[0][0] = GL;  ta[0][1] = GL;  ta[0][2] = GL;  ta[0][3] = GL;
        tb[0][0] = GHE; tb[0][1] = GHC; tb[0][2] = GHB; tb[0][3] = GHA;
        sd[1] = 16'hDF0F;
        ta[1][0] = 7'h00; ta[1][1] = G0; ta[1][2] = 7'h00; ta[1][3] = GL;
        tb[1][0] = 7'h00; tb[1][1] = G0; tb[1][2] = 7'h00; tb[1][3] = GHD;
        dp_in = 4'h0; lz_en = 1'b0;
        for (int s = 0; s < 2; s++) begin
            data = sd[s];
            start_scan();
            for (int k = 0; k < 32; k++) begin
                @(negedge clk);
                if ((k % 8) == 4) begin
                    d = k / 8;
                    vectors++;
                    if (seg_a !== ta[s][d]) begin
                        miscompares++;
                        $display("FAIL hex_a s=%0d d=%0d got %b need %b", s, d, seg_a, ta[s][d]);
                    end
                    vectors++;
                    if (seg_b !== ~tb[s][d]) begin
                        miscompares++;
                        $display("FAIL hex_b s=%0d d=%0d got %b need %b", s, d, seg_b, ~tb[s][d]);
                    end
                end
            end
        end
    endtask

    task automatic test_tearing();
        logic [6:0] es;
        logic [3:0] ed;
        data = 16'h1111; dp_in = 4'h0; lz_en = 1'b0;
        start_scan();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 17) data = 16'h2222;
            if ((k % 8) == 4) begin
                ed = 4'b0001 << ((k / 8) % 4);
                es = (k < 32) ? G1 : G2;
                vectors++;
                if ({dig_a, seg_a} !== {ed, es}) begin
                    miscompares++;
                    $display("FAIL tear_a k=%0d got %b need %b", k, {dig_a, seg_a}, {ed, es});
                end
                vectors++;
                if ({dig_b, seg_b} !== {~ed, ~es}) begin
                    miscompares++;
                    $display("FAIL tear_b k=%0d got %b need %b", k, {dig_b, seg_b}, {~ed, ~es});
                end
            end
        end
    endtask

    task automatic test_dp_reset();
        logic       edp;
        logic [3:0] ed;
        logic [6:0] es;
        int         d;
        data = 16'h1234; dp_in = 4'b0100; lz_en = 1'b0;
        start_scan();
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if ((k % 8) == 4) begin
                d   = k / 8;
                edp = (d == 2);
                vectors++;
                if ({dp_a, dp_b} !== {edp, ~edp}) begin
                    miscompares++;
                    $display("FAIL dp d=%0d got %b need %b", d, {dp_a, dp_b}, {edp, ~edp});
                end
            end
        end
        // Digit 2 is on display; pull reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({tick_a, dp_a, dig_a, seg_a, tick_b, dp_b, dig_b, seg_b} !==
            {13'h0, 1'b0, 1'b1, 4'hF, 7'h7F}) begin
            miscompares++;
            $display("FAIL async_reset got %b need %b", {tick_a, dp_a, dig_a, seg_a, tick_b, dp_b, dig_b, seg_b},
                     {13'h0, 1'b0, 1'b1, 4'hF, 7'h7F});
        end
        data = 16'h5678;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) begin
                vectors++;
                if ({tick_a, dig_a, tick_b, dig_b} !== {1'b1, 4'h0, 1'b1, 4'hF}) begin
                    miscompares++;
                    $display("FAIL restart_tick got %b need %b", {tick_a, dig_a, tick_b, dig_b},
                             {1'b1, 4'h0, 1'b1, 4'hF});
                end
            end
            if ((k % 8) == 4) begin
                ed = 4'b0001 << (k / 8);
                es = (k < 8) ? G8 : G7;
                vectors++;
                if ({dig_a, seg_a, dp_a, dig_b, seg_b, dp_b} !== {ed, es, 1'b0, ~ed, ~es, 1'b1}) begin
                    miscompares++;
                    $display("FAIL restart k=%0d got %b need %b", k, {dig_a, seg_a, dp_a, dig_b, seg_b, dp_b},
                             {ed, es, 1'b0, ~ed, ~es, 1'b1});
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        data   = 16'h0;
        dp_in  = 4'h0;
        lz_en  = 1'b0;
        test_reset();
        test_scan_timing();
        test_lz();
        test_hex();
        test_tearing();
        test_dp_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
